midi_event_arbiter: RTL and testbench
=====================================

Name: midi_event_arbiter

Overview:
- Shares the single MIDI event channel (midi_valid/midi_key/midi_velocity on clk_100MHz) between several event sources: MIDI UART parser, pad triggers and pattern sequencer.
- The channel feeds the note tracker and the sample voices.
- The block buffers one event per source and grants sources round-robin.
- It enforces a minimum spacing between output pulses, so each slower-clock consumer sees every toggle and gets stable key/velocity while it samples.

Parameters:
- NUM_SOURCES, 3, number of requesting sources (2..8).
- MIN_GAP, 16, idle clk_100MHz cycles forced after each output pulse (>=1).
- DROP_NOTE_OFF, 1, when 1, events with velocity 0 are accepted and discarded.

Ports:
- clk_100MHz  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NUM_SOURCES  per-source event valid.
- req_ready  output  NUM_SOURCES  per-source slot free.
- req_key  input  NUM_SOURCES x 7  per-source MIDI key (packed, source i at [7i+6:7i]).
- req_velocity  input  NUM_SOURCES x 7  per-source velocity (same packing).
- midi_valid  output  1  single-cycle event pulse.
- midi_key  output  7  key of last emitted event.
- midi_velocity  output  7  velocity of last emitted event.
- midi_src  output  $clog2(NUM_SOURCES)  source index of last emitted event.
- pending  output  NUM_SOURCES  held[] slot occupancy.

Behaviour:
- Reset (async, rst=1) clears the following: held[] = 0, key/vel slots = 0, rr pointer = 0, state = IDLE, midi_valid = 0, midi_key = 0, midi_velocity = 0, midi_src = 0.
- req_ready[i] = !held[i]. It is a combinational decode of the register only, with no dependence on req_valid.
- A transfer occurs on a rising edge with req_valid[i] && req_ready[i]:
  - Key and velocity are captured into slot i and held[i] <= 1.
  - Exception: DROP_NOTE_OFF=1 and velocity==0 → the transfer completes but nothing is stored.
- State machine with three states:
  - IDLE: if any held, pick the first set held[] at index >= ptr, wrapping modulo NUM_SOURCES.
  - On that grant the block registers midi_key/midi_velocity/midi_src from slot g, clears held[g], sets ptr <= (g+1) mod NUM_SOURCES and moves to EMIT.
  - If nothing is held, it stays in IDLE.
  - EMIT (1 cycle): midi_valid=1. Next state GAP with cnt <= MIN_GAP-1.
  - GAP: cnt decrements each cycle. At cnt==0 go to IDLE. GAP lasts exactly MIN_GAP cycles.
- midi_valid is high only in EMIT, as a registered output.
- midi_key, midi_velocity and midi_src keep their value until the next grant; they are never cleared by the pulse ending.
- Latency: handshake edge at cycle 0 → held at cycle 1 → midi_valid high at cycle 2, when the arbiter is IDLE.
- Minimum pulse spacing is MIN_GAP+2 cycles (18 at default).
- Refill: a granted source's req_ready goes high in the EMIT cycle. A new handshake then is legal and is stored normally. It competes at the next IDLE under round-robin.
- A source whose slot is full stalls via req_ready=0. No event is ever overwritten or lost except the note-offs discarded by DROP_NOTE_OFF.
- Simultaneous requests from all sources are all captured in the same cycle; one slot per source.
- Reset asserted mid-GAP or mid-EMIT: immediate return to reset values. Pending events are discarded and no pulse appears after release until a new handshake.
- Only held[] determines eligibility; req_valid deasserting after a transfer has no effect.

Test Plan:
- Single event: src0 key=36 vel=100 handshake at cycle 0 → midi_valid=1 only at cycle 2 with key=36, vel=100, src=0. Outputs still 36/100/0 at cycle 30; req_ready[0]=1 from cycle 2.
- All three sources present together at cycle 0 (keys 36, 38, 42) → pulses at cycles 2, 20, 38 carrying srcs 0, 1, 2. No other midi_valid highs.
- Round-robin fairness: after src0 granted, src0 and src1 both held → src1 granted next, then src0.
- Backpressure: src1 holds req_valid with keys 45 then 48 back to back → req_ready[1] low until the key-45 grant. Key 48 is emitted exactly 18 cycles after key 45, with no loss.
- Note-off: DROP_NOTE_OFF=1, src2 key=49 vel=0 → handshake completes and no pulse follows. With DROP_NOTE_OFF=0 → a pulse with vel=0.
- Reset in GAP: assert rst 5 cycles after a pulse while src1 is pending → all outputs 0 immediately and pending=0. No pulse for 40 cycles after release without new requests.

Source files
------------

// File: rtl/midi_event_arbiter_if.sv
// Event bus between the note sources (UART parser, pads, sequencer) and the
// arbiter that serialises them onto the single MIDI event channel.
interface midi_event_arbiter_if #(
  parameter int NUM_SOURCES = 3
);
  localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  logic [NUM_SOURCES-1:0]   req_valid;
  logic [NUM_SOURCES-1:0]   req_ready;
  logic [7*NUM_SOURCES-1:0] req_key;
  logic [7*NUM_SOURCES-1:0] req_velocity;
  logic                     midi_valid;
  logic [6:0]               midi_key;
  logic [6:0]               midi_velocity;
  logic [SRC_W-1:0]         midi_src;
  logic [NUM_SOURCES-1:0]   pending;

  modport master (
    output req_valid, req_key, req_velocity,
    input  req_ready, midi_valid, midi_key, midi_velocity, midi_src, pending
  );

  modport slave (
    input  req_valid, req_key, req_velocity,
    output req_ready, midi_valid, midi_key, midi_velocity, midi_src, pending
  );
endinterface

// File: rtl/midi_event_arbiter.sv
// One-slot-per-source buffer with round-robin grant; each emitted pulse is
// followed by MIN_GAP idle cycles so slower-clock consumers catch every event.
module midi_event_arbiter #(
  parameter int NUM_SOURCES   = 3,
  parameter int MIN_GAP       = 16,
  parameter bit DROP_NOTE_OFF = 1'b1
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  midi_event_arbiter_if.slave bus
);
  localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int CNT_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [SRC_W-1:0]            ptr_q, ptr_d;
  logic [NUM_SOURCES-1:0]      held_q, held_d;
  logic [NUM_SOURCES-1:0][6:0] key_q, key_d;
  logic [NUM_SOURCES-1:0][6:0] vel_q, vel_d;
  logic                        midi_valid_q, midi_valid_d;
  logic [6:0]                  midi_key_q, midi_key_d;
  logic [6:0]                  midi_vel_q, midi_vel_d;
  logic [SRC_W-1:0]            midi_src_q, midi_src_d;

  logic                        any_held;
  logic [SRC_W-1:0]            grant_idx;
  logic [NUM_SOURCES-1:0]      accept;
  logic [NUM_SOURCES-1:0]      store;

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                 input int unsigned      off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_SOURCES)) begin
      sum = sum - 32'(NUM_SOURCES);
    end else begin
      sum = sum;
    end
    return sum[SRC_W-1:0];
  endfunction

  // Round-robin pick: scan from the far end so the lowest offset from ptr wins.
  always_comb begin
    any_held  = |held_q;
    grant_idx = ptr_q;
    for (int off = NUM_SOURCES - 1; off >= 0; off--) begin
      if (held_q[wrap_add(ptr_q, 32'(off))]) begin
        grant_idx = wrap_add(ptr_q, 32'(off));
      end else begin
        grant_idx = grant_idx;
      end
    end
  end

  // Handshake decode; note-offs complete the handshake but are not stored.
  always_comb begin
    accept = bus.req_valid & ~held_q;
    store  = {NUM_SOURCES{1'b0}};
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (DROP_NOTE_OFF && (bus.req_velocity[7*i +: 7] == 7'd0)) begin
        store[i] = 1'b0;
      end else begin
        store[i] = accept[i];
      end
    end
  end

  // Slot capture, grant and pulse-spacing state machine.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    held_d       = held_q;
    key_d        = key_q;
    vel_d        = vel_q;
    midi_valid_d = 1'b0;
    midi_key_d   = midi_key_q;
    midi_vel_d   = midi_vel_q;
    midi_src_d   = midi_src_q;

    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (store[i]) begin
        held_d[i] = 1'b1;
        key_d[i]  = bus.req_key[7*i +: 7];
        vel_d[i]  = bus.req_velocity[7*i +: 7];
      end else begin
        held_d[i] = held_q[i];
      end
    end

    // A granted slot is never written in the same cycle: its ready was low.
    case (state_q)
      ST_IDLE: begin
        if (any_held) begin
          held_d[grant_idx] = 1'b0;
          midi_key_d        = key_q[grant_idx];
          midi_vel_d        = vel_q[grant_idx];
          midi_src_d        = grant_idx;
          ptr_d             = wrap_add(grant_idx, 32'd1);
          midi_valid_d      = 1'b1;
          state_d           = ST_EMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      ptr_q        <= {SRC_W{1'b0}};
      held_q       <= {NUM_SOURCES{1'b0}};
      key_q        <= {(7*NUM_SOURCES){1'b0}};
      vel_q        <= {(7*NUM_SOURCES){1'b0}};
      midi_valid_q <= 1'b0;
      midi_key_q   <= 7'd0;
      midi_vel_q   <= 7'd0;
      midi_src_q   <= {SRC_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      held_q       <= held_d;
      key_q        <= key_d;
      vel_q        <= vel_d;
      midi_valid_q <= midi_valid_d;
      midi_key_q   <= midi_key_d;
      midi_vel_q   <= midi_vel_d;
      midi_src_q   <= midi_src_d;
    end
  end

  assign bus.req_ready     = ~held_q;
  assign bus.pending       = held_q;
  assign bus.midi_valid    = midi_valid_q;
  assign bus.midi_key      = midi_key_q;
  assign bus.midi_velocity = midi_vel_q;
  assign bus.midi_src      = midi_src_q;
endmodule

// File: tb/tb_midi_event_arbiter.sv
// Bench for midi_event_arbiter: cycle-level reference model plus directed
// scenarios with hand-computed pulse timings.
module tb_midi_event_arbiter;
  localparam int NS      = 3;
  localparam int MIN_GAP = 16;

  logic          clk_100MHz;
  logic          rst = 1'b1;
  logic [NS-1:0] req_valid;
  logic [7*NS-1:0] req_key;
  logic [7*NS-1:0] req_vel;

  midi_event_arbiter_if #(.NUM_SOURCES(NS)) bus0();
  midi_event_arbiter_if #(.NUM_SOURCES(NS)) bus1();

  assign bus0.req_valid    = req_valid;
  assign bus0.req_key      = req_key;
  assign bus0.req_velocity = req_vel;
  assign bus1.req_valid    = req_valid;
  assign bus1.req_key      = req_key;
  assign bus1.req_velocity = req_vel;

  midi_event_arbiter #(.NUM_SOURCES(NS), .MIN_GAP(MIN_GAP), .DROP_NOTE_OFF(1'b1)) dut0 (
    .clk_100MHz(clk_100MHz), .rst(rst), .bus(bus0.slave));
  midi_event_arbiter #(.NUM_SOURCES(NS), .MIN_GAP(MIN_GAP), .DROP_NOTE_OFF(1'b0)) dut1 (
    .clk_100MHz(clk_100MHz), .rst(rst), .bus(bus1.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  int log0_rel[$], log0_key[$], log0_vel[$], log0_src[$];
  int log1_rel[$], log1_key[$], log1_vel[$], log1_src[$];

  // Reference model: slot contents, rotating priority and earliest next grant.
  logic [NS-1:0] m_held;
  logic [6:0]    m_key [NS];
  logic [6:0]    m_vel [NS];
  int            m_ptr, m_edge, m_last, m_osrc;
  logic          m_valid;
  logic [6:0]    m_okey, m_ovel;

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  initial forever begin
    @(posedge clk_100MHz);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_held  = '0;
    m_ptr   = 0;
    m_edge  = 0;
    m_last  = -1000;
    m_valid = 1'b0;
    m_okey  = 7'd0;
    m_ovel  = 7'd0;
    m_osrc  = 0;
    for (int i = 0; i < NS; i++) begin
      m_key[i] = 7'd0;
      m_vel[i] = 7'd0;
    end
  endtask

  // One clock edge: grants need a held slot and MIN_GAP+2 edges since the last grant.
  task automatic model_step();
    logic [NS-1:0] rdy;
    bit found;
    int s;
    rdy     = ~m_held;
    m_valid = 1'b0;
    found   = 1'b0;
    if (m_edge - m_last >= MIN_GAP + 2) begin
      for (int k = 0; k < NS; k++) begin
        s = (m_ptr + k) % NS;
        if (!found && m_held[s]) begin
          found     = 1'b1;
          m_held[s] = 1'b0;
          m_okey    = m_key[s];
          m_ovel    = m_vel[s];
          m_osrc    = s;
          m_ptr     = (s + 1) % NS;
          m_valid   = 1'b1;
          m_last    = m_edge;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (req_valid[i] && rdy[i] && (req_vel[7*i +: 7] != 7'd0)) begin
        m_held[i] = 1'b1;
        m_key[i]  = req_key[7*i +: 7];
        m_vel[i]  = req_vel[7*i +: 7];
      end
    end
    m_edge++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_100MHz or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle compare against the model, plus pulse logging for both DUTs.
  initial forever begin
    logic [NS-1:0] exp_ready;
    @(negedge clk_100MHz);
    exp_ready = ~m_held;
    chk("midi_valid",    bus0.midi_valid,    m_valid);
    chk("midi_key",      bus0.midi_key,      m_okey);
    chk("midi_velocity", bus0.midi_velocity, m_ovel);
    chk("midi_src",      bus0.midi_src,      m_osrc);
    chk("req_ready",     bus0.req_ready,     exp_ready);
    chk("pending",       bus0.pending,       m_held);
    if (bus0.midi_valid === 1'b1) begin
      log0_rel.push_back(cyc - t0);
      log0_key.push_back(int'(bus0.midi_key));
      log0_vel.push_back(int'(bus0.midi_velocity));
      log0_src.push_back(int'(bus0.midi_src));
    end
    if (bus1.midi_valid === 1'b1) begin
      log1_rel.push_back(cyc - t0);
      log1_key.push_back(int'(bus1.midi_key));
      log1_vel.push_back(int'(bus1.midi_velocity));
      log1_src.push_back(int'(bus1.midi_src));
    end
  end

  task automatic tick();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic run_to(input int rel);
    while (cyc - t0 < rel) tick();
  endtask

  task automatic set_src(input int i, input logic v, input logic [6:0] k, input logic [6:0] vl);
    req_valid[i]      = v;
    req_key[7*i +: 7] = k;
    req_vel[7*i +: 7] = vl;
  endtask

  task automatic clear_logs();
    log0_rel.delete(); log0_key.delete(); log0_vel.delete(); log0_src.delete();
    log1_rel.delete(); log1_key.delete(); log1_vel.delete(); log1_src.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  initial begin
    req_valid = '0;
    req_key   = '0;
    req_vel   = '0;
    tick();
    chk("reset_valid", bus0.midi_valid, 1'b0);
    chk("reset_pending", bus0.pending, 3'b000);
    chk("reset_ready", bus0.req_ready, 3'b111);
    do_reset();

    // Single event: pulse only at cycle 2, outputs held afterwards.
    t0 = cyc;
    set_src(0, 1'b1, 7'd36, 7'd100);
    tick();
    set_src(0, 1'b0, 7'd0, 7'd0);
    run_to(30);
    chk("t1_npulses", log0_rel.size(), 1);
    chk("t1_rel",     log0_rel[0], 2);
    chk("t1_key",     log0_key[0], 36);
    chk("t1_vel",     log0_vel[0], 100);
    chk("t1_src",     log0_src[0], 0);
    chk("t1_key_c30", bus0.midi_key, 7'd36);
    chk("t1_vel_c30", bus0.midi_velocity, 7'd100);
    chk("t1_src_c30", bus0.midi_src, 2'd0);
    chk("t1_ready0",  bus0.req_ready[0], 1'b1);
    do_reset();

    // All three sources at once: pulses at 2, 20, 38.
    t0 = cyc;
    set_src(0, 1'b1, 7'd36, 7'd100);
    set_src(1, 1'b1, 7'd38, 7'd100);
    set_src(2, 1'b1, 7'd42, 7'd100);
    tick();
    req_valid = '0;
    run_to(60);
    chk("t2_npulses", log0_rel.size(), 3);
    chk("t2_rel0", log0_rel[0], 2);
    chk("t2_rel1", log0_rel[1], 20);
    chk("t2_rel2", log0_rel[2], 38);
    chk("t2_src0", log0_src[0], 0);
    chk("t2_src1", log0_src[1], 1);
    chk("t2_src2", log0_src[2], 2);
    chk("t2_key2", log0_key[2], 42);
    do_reset();

    // Round-robin: after src0 wins, src1 goes ahead of a re-armed src0.
    t0 = cyc;
    set_src(0, 1'b1, 7'd60, 7'd80);
    tick();
    req_valid = '0;
    run_to(5);
    set_src(0, 1'b1, 7'd62, 7'd80);
    set_src(1, 1'b1, 7'd64, 7'd80);
    tick();
    req_valid = '0;
    run_to(50);
    chk("t3_npulses", log0_rel.size(), 3);
    chk("t3_src0", log0_src[0], 0);
    chk("t3_src1", log0_src[1], 1);
    chk("t3_src2", log0_src[2], 0);
    chk("t3_key2", log0_key[2], 62);
    chk("t3_rel2", log0_rel[2], 38);
    do_reset();

    // Backpressure: src1 keeps valid high with 45 then 48.
    begin
      bit accepted;
      accepted = 1'b0;
      t0 = cyc;
      set_src(1, 1'b1, 7'd45, 7'd90);
      tick();
      chk("t4_ready1_low", bus0.req_ready[1], 1'b0);
      set_src(1, 1'b1, 7'd48, 7'd90);
      for (int b = 0; b < 50 && !accepted; b++) begin
        if (bus0.req_ready[1] === 1'b1) accepted = 1'b1;
        tick();
      end
      chk("t4_stall_bounded", accepted, 1'b1);
      set_src(1, 1'b0, 7'd0, 7'd0);
      run_to(45);
      chk("t4_npulses", log0_rel.size(), 2);
      chk("t4_key0", log0_key[0], 45);
      chk("t4_key1", log0_key[1], 48);
      chk("t4_spacing", log0_rel[1] - log0_rel[0], 18);
    end
    do_reset();

    // Note-off: dropped by dut0, emitted by dut1.
    t0 = cyc;
    set_src(2, 1'b1, 7'd49, 7'd0);
    tick();
    set_src(2, 1'b0, 7'd0, 7'd0);
    chk("t5_pending_drop", bus0.pending, 3'b000);
    chk("t5_pending_keep", bus1.pending, 3'b100);
    run_to(40);
    chk("t5_drop_npulses", log0_rel.size(), 0);
    chk("t5_keep_npulses", log1_rel.size(), 1);
    chk("t5_keep_rel", log1_rel[0], 2);
    chk("t5_keep_key", log1_key[0], 49);
    chk("t5_keep_vel", log1_vel[0], 0);
    chk("t5_keep_src", log1_src[0], 2);
    do_reset();

    // Reset in GAP with src1 pending.
    t0 = cyc;
    set_src(0, 1'b1, 7'd36, 7'd100);
    tick();
    set_src(0, 1'b0, 7'd0, 7'd0);
    run_to(3);
    set_src(1, 1'b1, 7'd50, 7'd90);
    tick();
    set_src(1, 1'b0, 7'd0, 7'd0);
    run_to(7);
    chk("t6_pending_pre", bus0.pending, 3'b010);
    rst = 1'b1;
    #1;
    chk("t6_valid", bus0.midi_valid, 1'b0);
    chk("t6_key", bus0.midi_key, 7'd0);
    chk("t6_vel", bus0.midi_velocity, 7'd0);
    chk("t6_src", bus0.midi_src, 2'd0);
    chk("t6_pending", bus0.pending, 3'b000);
    tick();
    rst = 1'b0;
    clear_logs();
    t0 = cyc;
    run_to(40);
    chk("t6_npulses", log0_rel.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
